// File: rtl/regfile_write_demux.sv
// regfile_write_demux
// Buffers register-file write requests in a 2-entry in-order FIFO and drains
// them one per cycle into a registered one-hot write enable plus a broadcast
// data bus. Register 0 is hard-wired: its writes drain but never assert reg_we.
// Optional forwarding of pending/in-flight writes to a read port is built when
// the macro REGFILE_WRITE_BYPASS_EN is defined. Without it, byp_hit and
// byp_data are tied to zero.
module regfile_write_demux (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        stall,
    output logic [31:0] reg_we,
    output logic [31:0] reg_wdata,
    output logic [1:0]  pending,
    input  logic [4:0]  rd_addr,
    output logic        byp_hit,
    output logic [31:0] byp_data
);

    // Slot 0 is always the head; slot 1 holds the second (newer) entry.
    logic [1:0]  count_q, count_d;
    logic [4:0]  s0_addr_q, s0_addr_d;
    logic [31:0] s0_data_q, s0_data_d;
    logic [4:0]  s1_addr_q, s1_addr_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic [31:0] reg_we_q, reg_we_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;

    logic        push;
    logic        pop;
    logic [1:0]  wr_idx;

    // Handshake: a full FIFO refuses pushes even when it pops on the same edge.
    always_comb begin
        wr_ready = ~reset & (count_q != 2'd2);
        push     = wr_valid & wr_ready;
        pop      = (count_q != 2'd0) & ~stall;
        wr_idx   = count_q - {1'b0, pop};
    end

    // Next-state: shift the queue on pop, write the new entry behind the survivors,
    // and form the one-cycle write-enable pulse from the departing head.
    always_comb begin
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        s0_addr_d   = s0_addr_q;
        s0_data_d   = s0_data_q;
        s1_addr_d   = s1_addr_q;
        s1_data_d   = s1_data_q;
        reg_we_d    = 32'h0;
        reg_wdata_d = reg_wdata_q;

        if (pop) begin
            s0_addr_d   = s1_addr_q;
            s0_data_d   = s1_data_q;
            reg_wdata_d = s0_data_q;
            if (s0_addr_q != 5'd0) begin
                reg_we_d = 32'd1 << s0_addr_q;
            end
        end

        if (push) begin
            if (wr_idx == 2'd0) begin
                s0_addr_d = wr_addr;
                s0_data_d = wr_data;
            end else begin
                s1_addr_d = wr_addr;
                s1_data_d = wr_data;
            end
        end
    end

    // State registers; reset discards everything, including the in-flight pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= 2'd0;
            s0_addr_q   <= 5'd0;
            s0_data_q   <= 32'h0;
            s1_addr_q   <= 5'd0;
            s1_data_q   <= 32'h0;
            reg_we_q    <= 32'h0;
            reg_wdata_q <= 32'h0;
        end else begin
            count_q     <= count_d;
            s0_addr_q   <= s0_addr_d;
            s0_data_q   <= s0_data_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign pending   = count_q;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic [4:0]  tail_addr;
    logic [31:0] tail_data;

    // Forwarding: newest matching write wins (tail, then head, then the write
    // currently presented on reg_we). Register 0 never forwards.
    always_comb begin
        tail_addr = (count_q == 2'd2) ? s1_addr_q : s0_addr_q;
        tail_data = (count_q == 2'd2) ? s1_data_q : s0_data_q;
        byp_hit   = 1'b0;
        byp_data  = 32'h0;
        if (rd_addr != 5'd0) begin
            if ((count_q != 2'd0) && (tail_addr == rd_addr)) begin
                byp_hit  = 1'b1;
                byp_data = tail_data;
            end else if ((count_q != 2'd0) && (s0_addr_q == rd_addr)) begin
                byp_hit  = 1'b1;
                byp_data = s0_data_q;
            end else if (reg_we_q[rd_addr]) begin
                byp_hit  = 1'b1;
                byp_data = reg_wdata_q;
            end
        end
    end
`else
    logic unused_rd_addr;

    // Forwarding disabled: outputs tied off, read index ignored.
    always_comb begin
        unused_rd_addr = ^rd_addr;
        byp_hit        = 1'b0;
        byp_data       = 32'h0;
    end
`endif

endmodule

// File: tb/tb_regfile_write_demux.sv
// Bench for regfile_write_demux: directed scenarios followed by random traffic,
// every output compared each cycle against a queue-based reference model.
// Forwarding expectations follow the REGFILE_WRITE_BYPASS_EN macro.
module tb_regfile_write_demux;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] reg_we;
    logic [31:0] reg_wdata;
    logic [1:0]  pending;
    logic [4:0]  rd_addr = 5'd0;
    logic        byp_hit;
    logic [31:0] byp_data;

    regfile_write_demux dut (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .stall    (stall),
        .reg_we   (reg_we),
        .reg_wdata(reg_wdata),
        .pending  (pending),
        .rd_addr  (rd_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_we    = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [4:0]  m_last  = 5'd0;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_byp(input logic [4:0] r, output logic h, output logic [31:0] dd);
        h  = 1'b0;
        dd = 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (r != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!h && q[i].a == r) begin
                    h  = 1'b1;
                    dd = q[i].d;
                end
            end
            if (!h && m_we != 32'h0 && m_last == r) begin
                h  = 1'b1;
                dd = m_wdata;
            end
        end
`endif
    endfunction

    task automatic check_all();
        logic        eh;
        logic [31:0] ed;
        model_byp(rd_addr, eh, ed);
        chk("pending",   {30'h0, pending},  q.size());
        chk("wr_ready",  {31'h0, wr_ready}, {31'h0, (q.size() < 2)});
        chk("reg_we",    reg_we,    m_we);
        chk("reg_wdata", reg_wdata, m_wdata);
        chk("byp_hit",   {31'h0, byp_hit},  {31'h0, eh});
        chk("byp_data",  byp_data,  ed);
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    // to what the following rising edge will produce.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic [4:0] r);
        ent_t e;
        bit   do_pop;
        bit   do_push;
        @(negedge clock);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        stall    = s;
        rd_addr  = r;
        #1;
        check_all();
        do_pop  = (q.size() > 0) && !s;
        do_push = v && (q.size() < 2);
        if (do_pop) begin
            e       = q.pop_front();
            m_we    = (e.a == 5'd0) ? 32'h0 : (32'd1 << e.a);
            m_wdata = e.d;
            m_last  = e.a;
        end else begin
            m_we = 32'h0;
        end
        if (do_push) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
    endtask

    // Asynchronous reset between edges, held for two cycles with requests offered.
    task automatic mid_reset(input logic [4:0] r);
        @(negedge clock);
        rd_addr  = r;
        wr_valid = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'h4444;
        stall    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pending",  {30'h0, pending},  32'h0);
        chk("rst_reg_we",   reg_we,            32'h0);
        chk("rst_wdata",    reg_wdata,         32'h0);
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("rst_byp_hit",  {31'h0, byp_hit},  32'h0);
        q.delete();
        m_we    = 32'h0;
        m_wdata = 32'h0;
        m_last  = 5'd0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_pending", {30'h0, pending}, 32'h0);
        chk("rst_hold_reg_we",  reg_we,           32'h0);
        @(negedge clock);
        reset    = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("rst_release_ready", {31'h0, wr_ready}, 32'h1);
    endtask

    initial begin
        #1;
        chk("init_pending",  {30'h0, pending},  32'h0);
        chk("init_reg_we",   reg_we,            32'h0);
        chk("init_wdata",    reg_wdata,         32'h0);
        chk("init_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("init_byp_hit",  {31'h0, byp_hit},  32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single write to r5.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);

        // Fill under stall, third request refused, then drain back-to-back.
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd3);
        step(1'b1, 5'd7, 32'hA7, 1'b1, 5'd3);
        step(1'b1, 5'd9, 32'hA9, 1'b1, 5'd7);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);

        // Write to r0 drains without an enable pulse.
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Two writes to r9 held by stall: newest forwarded, r0 never forwarded.
        step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9);
        step(1'b1, 5'd9, 32'hB, 1'b1, 5'd9);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);

        // Reset with a full FIFO, then confirm nothing drains afterwards.
        mid_reset(5'd9);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9);

        // Random traffic over a small address range so forwarding hits often.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra;
            logic [4:0] rr;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rr = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 2) != 0), ra, $urandom, 1'($urandom_range(0, 2) == 0), rr);
            if (n == 200) begin
                mid_reset(rr);
            end
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd2);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_demux.md
REGFILE_WRITE_DEMUX -- requirements
Module: regfile_write_demux

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: wr_valid  input  1  write request present.
REQ-004 SHALL have port: wr_ready  output  1  block can accept a request this cycle.
REQ-005 SHALL have port: wr_addr  input  5  destination register index.
REQ-006 SHALL have port: wr_data  input  32  write data.
REQ-007 SHALL have port: stall  input  1  register array not accepting writes this cycle.
REQ-008 SHALL have port: reg_we  output  32  one-hot per-register write enable, registered.
REQ-009 SHALL have port: reg_wdata  output  32  data broadcast to all registers, registered.
REQ-010 SHALL have port: pending  output  2  buffered entries, 0..2.
REQ-011 SHALL have port: rd_addr  input  5  read-port index checked for forwarding.
REQ-012 SHALL have port: byp_hit  output  1  newer write to rd_addr pending or in flight.
REQ-013 SHALL have port: byp_data  output  32  forwarded data when byp_hit=1.

Function
REQ-014 SHALL hold requests in a 2-entry in-order FIFO; push when wr_valid=1 and wr_ready=1 at a rising edge.
REQ-015 SHALL drive wr_ready=1 iff pending<2, from state only, independent of wr_valid and stall.
REQ-016 SHALL not push when full, even if a pop occurs in the same cycle.
REQ-017 SHALL pop the head at an edge when pending>0 and stall=0; push and pop in the same edge SHALL leave pending unchanged.
REQ-018 On a pop, SHALL load reg_we with one-hot decode of head addr (bit k set for addr k) and reg_wdata with head data, valid for exactly one cycle.
REQ-019 Head addr 0 SHALL pop normally but load reg_we=32'h0 (r0 never written); reg_wdata still loads.
REQ-020 On any edge without a pop (empty or stall=1), reg_we SHALL load 0; reg_wdata SHALL hold.
REQ-021 Latency: request pushed into empty FIFO at edge N, no stall, SHALL appear on reg_we during the cycle after edge N+1.
REQ-022 Sustained throughput SHALL be one write per cycle with no stall.
REQ-023 reg_we SHALL never have more than one bit set.
REQ-024 byp_hit SHALL be combinational: 1 iff rd_addr!=0 and rd_addr matches the tail entry, head entry or active reg_we entry; priority tail > head > reg_we entry; byp_data from the winning entry, else 0.

Reset
REQ-025 reset=1 SHALL immediately, without a clock, clear FIFO, pending=0, reg_we=0, reg_wdata=0.
REQ-026 While reset=1, wr_ready SHALL be 0 and byp_hit 0; wr_ready SHALL return to 1 in the first cycle after deassertion.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight writes with no reg_we pulse for them.

Configuration
REQ-028 Macro REGFILE_WRITE_BYPASS_EN SHALL control forwarding.
REQ-029 Defined: byp_hit/byp_data SHALL behave per REQ-024.
REQ-030 Undefined: ports SHALL remain; byp_hit SHALL be constant 0, byp_data 32'h0, no compare logic; all other behaviour identical.

Verification
REQ-031 Reset, then push addr=5 data=32'hDEADBEEF, stall=0 -> reg_we=32'h00000020, reg_wdata=32'hDEADBEEF one cycle after next edge, then reg_we=0.
REQ-032 stall=1, push addr 3 then 7 -> pending=2, wr_ready=0, third request ignored; release stall -> reg_we=32'h8 then 32'h80 on consecutive cycles.
REQ-033 Push addr=0 data=32'h1234 -> reg_we stays 0, pending returns to 0.
REQ-034 Bypass build: stall=1, push (9,32'hA),(9,32'hB), rd_addr=9 -> byp_hit=1, byp_data=32'hB; rd_addr=0 -> byp_hit=0; non-bypass build -> byp_hit=0.
REQ-035 pending=2, assert reset between edges -> reg_we=0, pending=0 immediately; no write pulses afterwards.
